// File: rtl/zebu_rst_seq_if.sv
// Handshake and status bundle for the multi-channel reset sequencer.
// master: the controlling side (bench or SoC glue); slave: the sequencer itself.
interface zebu_rst_seq_if #(
    parameter int NUM_CH = 4
);
    logic              sw_req;
    logic [NUM_CH-1:0] ch_mask;
    logic              wdog_kick;
    logic [NUM_CH-1:0] rst_n_out;
    logic              busy;
    logic              done;
    logic [7:0]        seq_count;
    logic              wdog_fired;

    modport master (
        output sw_req, ch_mask, wdog_kick,
        input  rst_n_out, busy, done, seq_count, wdog_fired
    );

    modport slave (
        input  sw_req, ch_mask, wdog_kick,
        output rst_n_out, busy, done, seq_count, wdog_fired
    );
endinterface

// File: rtl/zebu_rst_seq.sv
// Multi-channel reset sequencer: PRE delay, common assert window, then
// staggered per-channel release, with software re-trigger.
// Optional watchdog enabled by defining ZEBU_RST_SEQ_WDOG_EN.
// A single counter spans ASSERT and RELEASE: channel i is held low while
// the counter is below ASSERT_CYCLES + i*STAGGER_CYCLES.
module zebu_rst_seq #(
    parameter int NUM_CH         = 4,
    parameter int PRE_CYCLES     = 5,
    parameter int ASSERT_CYCLES  = 20,
    parameter int STAGGER_CYCLES = 8,
    parameter int CNT_W          = 16,
    parameter int WDOG_CYCLES    = 1000
) (
    input  logic           clk,
    input  logic           rst,
    zebu_rst_seq_if.slave  bus
);

    localparam logic [1:0] ST_PRE     = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;

    localparam logic [CNT_W-1:0] PRE_END   = CNT_W'(PRE_CYCLES);
    localparam logic [CNT_W-1:0] REL_START = CNT_W'(ASSERT_CYCLES);
    localparam logic [CNT_W-1:0] SEQ_END   = CNT_W'(ASSERT_CYCLES + (NUM_CH - 1) * STAGGER_CYCLES);

    logic [1:0]        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_inc;
    logic [NUM_CH-1:0] mask_reg, mask_next;
    logic              sw_req_reg;
    logic              done_reg, done_next;
    logic [7:0]        seq_count_reg, seq_count_next;
    logic              busy_reg;
    logic [NUM_CH-1:0] rst_n_reg, rst_n_next;
    logic              seq_active_next;
    logic              wdog_hit;

    assign cnt_inc         = cnt_reg + 1'b1;
    assign seq_active_next = (state_next == ST_ASSERT) || (state_next == ST_RELEASE);

    // Next-state logic; a sampled request restarts the assert window one edge later
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        mask_next      = mask_reg;
        done_next      = 1'b0;
        seq_count_next = seq_count_reg;
        case (state_reg)
            ST_PRE: begin
                if (cnt_reg == PRE_END) begin
                    state_next = ST_ASSERT;
                    cnt_next   = '0;
                    mask_next  = bus.ch_mask;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            ST_ASSERT, ST_RELEASE: begin
                if (sw_req_reg) begin
                    // restart keeps the mask latched for this sequence
                    state_next = ST_ASSERT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == SEQ_END) begin
                        state_next = ST_RUN;
                        done_next  = 1'b1;
                        if (seq_count_reg != 8'hFF) begin
                            seq_count_next = seq_count_reg + 8'd1;
                        end
                    end else if (cnt_inc >= REL_START) begin
                        state_next = ST_RELEASE;
                    end else begin
                        state_next = ST_ASSERT;
                    end
                end
            end
            default: begin
                if (sw_req_reg || wdog_hit) begin
                    state_next = ST_ASSERT;
                    cnt_next   = '0;
                    mask_next  = bus.ch_mask;
                end
            end
        endcase
    end

    // Per-channel release threshold; slots are by index regardless of mask
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        localparam logic [CNT_W-1:0] REL_AT = CNT_W'(ASSERT_CYCLES + gi * STAGGER_CYCLES);
        assign rst_n_next[gi] = !(mask_next[gi] && seq_active_next && (cnt_next < REL_AT));
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_PRE;
            cnt_reg       <= '0;
            mask_reg      <= '1;
            sw_req_reg    <= 1'b0;
            done_reg      <= 1'b0;
            seq_count_reg <= 8'd0;
            busy_reg      <= 1'b1;
            rst_n_reg     <= '1;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            mask_reg      <= mask_next;
            sw_req_reg    <= bus.sw_req;
            done_reg      <= done_next;
            seq_count_reg <= seq_count_next;
            busy_reg      <= (state_reg != ST_RUN);
            rst_n_reg     <= rst_n_next;
        end
    end

`ifdef ZEBU_RST_SEQ_WDOG_EN
    localparam logic [CNT_W-1:0] WDOG_END = CNT_W'(WDOG_CYCLES - 1);

    logic [CNT_W-1:0] wdog_cnt_reg;
    logic             wdog_hit_reg;
    logic             wdog_fired_reg;

    // Watchdog counts only in RUN; expiry behaves like a sampled sw_req
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt_reg   <= '0;
            wdog_hit_reg   <= 1'b0;
            wdog_fired_reg <= 1'b0;
        end else begin
            wdog_hit_reg <= 1'b0;
            if (state_reg != ST_RUN) begin
                wdog_cnt_reg <= '0;
            end else begin
                if (bus.wdog_kick) begin
                    wdog_cnt_reg <= '0;
                end else begin
                    wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
                end
                // a same-cycle sw_req takes the restart instead of the watchdog
                wdog_hit_reg <= (wdog_cnt_reg == WDOG_END) && !bus.wdog_kick && !bus.sw_req;
            end
            if (wdog_hit_reg && (state_reg == ST_RUN)) begin
                wdog_fired_reg <= 1'b1;
            end
        end
    end

    assign wdog_hit       = wdog_hit_reg;
    assign bus.wdog_fired = wdog_fired_reg;
`else
    logic unused_wdog;
    assign unused_wdog    = bus.wdog_kick | (WDOG_CYCLES < 0);
    assign wdog_hit       = 1'b0;
    assign bus.wdog_fired = 1'b0;
`endif

    assign bus.rst_n_out = rst_n_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.seq_count = seq_count_reg;

endmodule

// File: tb/tb_zebu_rst_seq.sv
// Self-checking bench for zebu_rst_seq: directed scenarios with fixed cycle
// expectations, plus randomized traffic against a timeline reference model.
module tb_zebu_rst_seq;

    localparam int NCH    = 4;
    localparam int PRE    = 5;
    localparam int ASRT   = 20;
    localparam int STAG   = 8;
    localparam int LAST   = ASRT + (NCH - 1) * STAG;
`ifdef ZEBU_RST_SEQ_WDOG_EN
    localparam bit WD_EN  = 1'b1;
`else
    localparam bit WD_EN  = 1'b0;
`endif
    localparam int WDOG   = 10;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    zebu_rst_seq_if #(.NUM_CH(NCH)) bus ();

    zebu_rst_seq #(
        .NUM_CH(NCH), .PRE_CYCLES(PRE), .ASSERT_CYCLES(ASRT),
        .STAGGER_CYCLES(STAG), .CNT_W(16), .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: sequence origin time plus per-channel release offsets
    int             cyc;
    bit             m_started, m_run, m_pending, m_done, m_busy, m_fired;
    int             m_origin, m_wref, m_count;
    logic [NCH-1:0] m_mask;

    task automatic model_edge(input logic r, input logic sw, input logic [NCH-1:0] m, input logic k);
        bit fire;
        if (r) begin
            cyc = -1; m_started = 0; m_run = 0; m_pending = 0; m_done = 0;
            m_busy = 1; m_fired = 0; m_origin = 0; m_wref = 0; m_count = 0; m_mask = '1;
        end else begin
            cyc++;
            m_busy = !m_run;
            m_done = 0;
            fire = WD_EN && m_run && !m_pending && (cyc == m_wref + WDOG + 1);
            if (!m_started) begin
                if (cyc == PRE) begin
                    m_started = 1; m_origin = cyc; m_mask = m;
                end
            end else if (m_pending || fire) begin
                if (fire) m_fired = 1;
                if (m_run) m_mask = m;
                m_origin = cyc;
                m_run = 0;
            end else if (!m_run && (cyc - m_origin == LAST)) begin
                m_run = 1; m_done = 1; m_wref = cyc;
                if (m_count < 255) m_count++;
            end else if (m_run && k) begin
                m_wref = cyc;
            end
            m_pending = sw;
        end
    endtask

    task automatic step(input logic r, input logic sw, input logic [NCH-1:0] m, input logic k);
        @(negedge clk);
        rst = r; bus.sw_req = sw; bus.ch_mask = m; bus.wdog_kick = k;
        @(posedge clk);
        model_edge(r, sw, m, k);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b1, 4'h0, 1'b0);
            checks++; if (bus.rst_n_out !== 4'hF) begin failures++; $display("FAIL reset_rst_n got=%b exp=1111", bus.rst_n_out); end
            checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", bus.busy); end
            checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
            checks++; if (bus.seq_count !== 8'd0) begin failures++; $display("FAIL reset_seq_count got=%0d exp=0", bus.seq_count); end
            checks++; if (bus.wdog_fired !== 1'b0) begin failures++; $display("FAIL reset_wdog_fired got=%b exp=0", bus.wdog_fired); end
        end
        $display("test_reset done");
    endtask

    task automatic test_default_seq(input logic [NCH-1:0] mask, input string nm);
        logic [NCH-1:0] exp_n;
        step(1'b1, 1'b0, mask, 1'b1);
        for (int c = 0; c <= 60; c++) begin
            step(1'b0, 1'b0, mask, 1'b1);
            exp_n = '1;
            for (int i = 0; i < NCH; i++) if (mask[i] && c >= 5 && c < 25 + 8 * i) exp_n[i] = 1'b0;
            checks++; if (bus.rst_n_out !== exp_n) begin failures++; $display("FAIL %s_rst_n t=%0d got=%b exp=%b", nm, c, bus.rst_n_out, exp_n); end
            checks++; if (bus.done !== (c == 49)) begin failures++; $display("FAIL %s_done t=%0d got=%b exp=%b", nm, c, bus.done, c == 49); end
            checks++; if (bus.busy !== (c < 50)) begin failures++; $display("FAIL %s_busy t=%0d got=%b exp=%b", nm, c, bus.busy, c < 50); end
            checks++; if (bus.seq_count !== ((c >= 49) ? 8'd1 : 8'd0)) begin failures++; $display("FAIL %s_seq_count t=%0d got=%0d", nm, c, bus.seq_count); end
        end
        $display("test_default_seq %s mask=%b done", nm, mask);
    endtask

    task automatic test_run_retrigger();
        logic [NCH-1:0] exp_n;
        step(1'b1, 1'b0, 4'hF, 1'b1);
        for (int c = 0; c <= 150; c++) begin
            step(1'b0, (c == 100), 4'hF, 1'b1);
            if (c < 100) continue;
            exp_n = '1;
            for (int i = 0; i < NCH; i++) if (c >= 101 && c < 121 + 8 * i) exp_n[i] = 1'b0;
            checks++; if (bus.rst_n_out !== exp_n) begin failures++; $display("FAIL run_retrig_rst_n t=%0d got=%b exp=%b", c, bus.rst_n_out, exp_n); end
            checks++; if (bus.done !== (c == 145)) begin failures++; $display("FAIL run_retrig_done t=%0d got=%b", c, bus.done); end
            checks++; if (bus.busy !== (c >= 102 && c <= 145)) begin failures++; $display("FAIL run_retrig_busy t=%0d got=%b", c, bus.busy); end
            checks++; if (bus.seq_count !== ((c >= 145) ? 8'd2 : 8'd1)) begin failures++; $display("FAIL run_retrig_seq_count t=%0d got=%0d", c, bus.seq_count); end
        end
        $display("test_run_retrigger done");
    endtask

    task automatic test_release_retrigger();
        logic [NCH-1:0] exp_n;
        step(1'b1, 1'b0, 4'hF, 1'b1);
        for (int c = 0; c <= 85; c++) begin
            step(1'b0, (c == 36), 4'hF, 1'b1);
            exp_n = '1;
            for (int i = 0; i < NCH; i++) begin
                if (c < 37 && c >= 5 && c < 25 + 8 * i) exp_n[i] = 1'b0;
                if (c >= 37 && c < 57 + 8 * i) exp_n[i] = 1'b0;
            end
            checks++; if (bus.rst_n_out !== exp_n) begin failures++; $display("FAIL rel_retrig_rst_n t=%0d got=%b exp=%b", c, bus.rst_n_out, exp_n); end
            checks++; if (bus.done !== (c == 81)) begin failures++; $display("FAIL rel_retrig_done t=%0d got=%b", c, bus.done); end
            checks++; if (bus.busy !== (c < 82)) begin failures++; $display("FAIL rel_retrig_busy t=%0d got=%b", c, bus.busy); end
            checks++; if (bus.seq_count !== ((c >= 81) ? 8'd1 : 8'd0)) begin failures++; $display("FAIL rel_retrig_seq_count t=%0d got=%0d", c, bus.seq_count); end
        end
        $display("test_release_retrigger done");
    endtask

    task automatic test_rst_mid();
        step(1'b1, 1'b0, 4'hF, 1'b1);
        for (int c = 0; c < 30; c++) step(1'b0, 1'b0, 4'hF, 1'b1);
        step(1'b1, 1'b0, 4'hF, 1'b1);
        checks++; if (bus.rst_n_out !== 4'hF) begin failures++; $display("FAIL rst_mid_rst_n got=%b exp=1111", bus.rst_n_out); end
        checks++; if (bus.seq_count !== 8'd0) begin failures++; $display("FAIL rst_mid_seq_count got=%0d exp=0", bus.seq_count); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy got=%b exp=1", bus.busy); end
        for (int c = 0; c <= 10; c++) begin
            step(1'b0, 1'b0, 4'hF, 1'b1);
            checks++;
            if (bus.rst_n_out !== ((c >= 5) ? 4'h0 : 4'hF)) begin
                failures++; $display("FAIL rst_mid_restart t=%0d got=%b", c, bus.rst_n_out);
            end
        end
        $display("test_rst_mid done");
    endtask

`ifdef ZEBU_RST_SEQ_WDOG_EN
    task automatic test_wdog();
        step(1'b1, 1'b0, 4'hF, 1'b0);
        for (int c = 0; c <= 60; c++) begin
            step(1'b0, 1'b0, 4'hF, 1'b0);
            checks++; if (bus.wdog_fired !== (c >= 60)) begin failures++; $display("FAIL wdog_fired t=%0d got=%b", c, bus.wdog_fired); end
            if (c >= 59) begin
                checks++;
                if (bus.rst_n_out !== ((c == 60) ? 4'h0 : 4'hF)) begin
                    failures++; $display("FAIL wdog_rst_n t=%0d got=%b", c, bus.rst_n_out);
                end
            end
        end
        step(1'b1, 1'b0, 4'hF, 1'b0);
        for (int c = 0; c <= 150; c++) begin
            step(1'b0, 1'b0, 4'hF, (c % 5 == 0));
            checks++; if (bus.wdog_fired !== 1'b0) begin failures++; $display("FAIL wdog_kicked_fired t=%0d got=%b", c, bus.wdog_fired); end
            if (c >= 50) begin
                checks++; if (bus.rst_n_out !== 4'hF) begin failures++; $display("FAIL wdog_kicked_rst_n t=%0d got=%b", c, bus.rst_n_out); end
            end
        end
        $display("test_wdog done");
    endtask
`endif

    task automatic test_random();
        logic [NCH-1:0] exp_n;
        logic [NCH-1:0] mask;
        logic sw, k, r;
        int hold;
        hold = 0;
        mask = 4'($urandom);
        step(1'b1, 1'b0, mask, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            if (hold > 0) begin sw = 1'b1; hold--; end
            else if ($urandom_range(0, 79) == 0) begin sw = 1'b1; hold = $urandom_range(0, 6); end
            else sw = 1'b0;
            if ($urandom_range(0, 19) == 0) mask = 4'($urandom);
            k = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 599) == 0);
            step(r, sw, mask, k);
            exp_n = '1;
            for (int i = 0; i < NCH; i++)
                if (m_started && !m_run && m_mask[i] && (cyc - m_origin) < ASRT + i * STAG) exp_n[i] = 1'b0;
            if (m_done) $display("random sequence done t=%0d count=%0d mask=%b", cyc, m_count, m_mask);
            checks++; if (bus.rst_n_out !== exp_n) begin failures++; $display("FAIL rand_rst_n n=%0d got=%b exp=%b", n, bus.rst_n_out, exp_n); end
            checks++; if (bus.done !== m_done) begin failures++; $display("FAIL rand_done n=%0d got=%b exp=%b", n, bus.done, m_done); end
            checks++; if (bus.busy !== m_busy) begin failures++; $display("FAIL rand_busy n=%0d got=%b exp=%b", n, bus.busy, m_busy); end
            checks++; if (bus.seq_count !== 8'(m_count)) begin failures++; $display("FAIL rand_seq_count n=%0d got=%0d exp=%0d", n, bus.seq_count, m_count); end
            checks++; if (bus.wdog_fired !== m_fired) begin failures++; $display("FAIL rand_wdog_fired n=%0d got=%b exp=%b", n, bus.wdog_fired, m_fired); end
        end
        $display("test_random done");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.sw_req = 1'b0;
        bus.ch_mask = '1;
        bus.wdog_kick = 1'b0;
        test_reset();
        test_default_seq(4'hF, "full");
        test_default_seq(4'b0101, "mask0101");
        test_run_retrigger();
        test_release_retrigger();
        test_rst_mid();
`ifdef ZEBU_RST_SEQ_WDOG_EN
        test_wdog();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
